// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction-fetch and load/store requests onto a
// byte-wide synchronous RAM with one cycle of read latency.
// Optional build macro: MEM_ARB_RR_EN selects round-robin arbitration on ties.
// Without it, the LSB side wins ties.
`timescale 1ns/1ps
module mem_arbiter (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  // fetch side
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_data,
  // load/store side
  input  logic        lsb_req,
  input  logic        lsb_wr,
  input  logic [1:0]  lsb_len,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_ready,
  output logic [31:0] lsb_rdata,
  // control
  input  logic        clear,
  output logic        mem_busy,
  // RAM side
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, LOAD = 2'd2, STORE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;          // byte index k within the transfer
  logic [2:0]  nbytes_q, nbytes_d;    // transfer length N in bytes
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;          // read assembly buffer
  logic        if_ready_q, if_ready_d;
  logic        lsb_ready_q, lsb_ready_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] lsb_rdata_q, lsb_rdata_d;
  // The RAM keeps running while rdy_in is low, so the byte that was on
  // mem_din when the pause began is parked here and used on resume.
  logic [7:0]  din_hold_q, din_hold_d;
  logic        paused_q, paused_d;
`ifdef MEM_ARB_RR_EN
  logic        last_lsb_q, last_lsb_d; // 1 = LSB won the most recent grant
`endif

  logic        grant_lsb;
  logic        grant_if;
  logic [7:0]  din_eff;
  logic [31:0] rd_word;
  logic [7:0]  wr_byte;
  logic [2:0]  len_bytes;

  assign din_eff = paused_q ? din_hold_q : mem_din;

  // Byte k-1 of the read result is taken from the RAM while cnt == k.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_word[8*gi +: 8] = (cnt_q == 3'(gi + 1)) ? din_eff : buf_q[8*gi +: 8];
  end

  assign wr_byte = wdata_q[{cnt_q[1:0], 3'b000} +: 8];

  // Decode the LSB length code into a byte count.
  always_comb begin
    case (lsb_len)
      2'd0:    len_bytes = 3'd1;
      2'd1:    len_bytes = 3'd2;
      default: len_bytes = 3'd4;
    endcase
  end

  // Arbitration between the two requesters when the FSM is idle.
  always_comb begin
`ifdef MEM_ARB_RR_EN
    grant_lsb = lsb_req && (!if_req || !last_lsb_q);
`else
    grant_lsb = lsb_req;
`endif
    grant_if = if_req && !grant_lsb;
  end

  // Next-state logic: grant, byte sequencing, completion and flush.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nbytes_d    = nbytes_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_ready_d  = if_ready_q;
    lsb_ready_d = lsb_ready_q;
    if_data_d   = if_data_q;
    lsb_rdata_d = lsb_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_lsb_d  = last_lsb_q;
`endif
    paused_d    = ~rdy_in;
    din_hold_d  = (!rdy_in && !paused_q) ? mem_din : din_hold_q;

    if (rdy_in) begin
      if_ready_d  = 1'b0;
      lsb_ready_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (!clear && grant_lsb) begin
            state_d  = lsb_wr ? STORE : LOAD;
            base_d   = lsb_addr;
            wdata_d  = lsb_wr ? lsb_wdata : 32'h0;
            nbytes_d = len_bytes;
            cnt_d    = 3'd0;
            buf_d    = 32'h0;
`ifdef MEM_ARB_RR_EN
            last_lsb_d = 1'b1;
`endif
          end else if (!clear && grant_if) begin
            state_d  = FETCH;
            base_d   = if_addr;
            wdata_d  = 32'h0;
            nbytes_d = 3'd4;
            cnt_d    = 3'd0;
            buf_d    = 32'h0;
`ifdef MEM_ARB_RR_EN
            last_lsb_d = 1'b0;
`endif
          end
        end
        FETCH, LOAD: begin
          if (clear) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
          end else begin
            buf_d = rd_word;
            if (cnt_q == nbytes_q) begin
              state_d = IDLE;
              cnt_d   = 3'd0;
              if (state_q == FETCH) begin
                if_ready_d = 1'b1;
                if_data_d  = rd_word;
              end else begin
                lsb_ready_d = 1'b1;
                lsb_rdata_d = rd_word;
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        STORE: begin
          // Committed stores run to completion even across a flush.
          if (cnt_q == nbytes_q - 3'd1) begin
            state_d     = IDLE;
            cnt_d       = 3'd0;
            lsb_ready_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      nbytes_q    <= 3'd0;
      base_q      <= 32'h0;
      wdata_q     <= 32'h0;
      buf_q       <= 32'h0;
      if_ready_q  <= 1'b0;
      lsb_ready_q <= 1'b0;
      if_data_q   <= 32'h0;
      lsb_rdata_q <= 32'h0;
      din_hold_q  <= 8'h0;
      paused_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_lsb_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nbytes_q    <= nbytes_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_ready_q  <= if_ready_d;
      lsb_ready_q <= lsb_ready_d;
      if_data_q   <= if_data_d;
      lsb_rdata_q <= lsb_rdata_d;
      din_hold_q  <= din_hold_d;
      paused_q    <= paused_d;
`ifdef MEM_ARB_RR_EN
      last_lsb_q  <= last_lsb_d;
`endif
    end
  end

  // RAM drive: address only during byte cycles, write data only for stores,
  // and never a write strobe while paused.
  always_comb begin
    mem_a    = 32'h0;
    mem_dout = 8'h0;
    mem_wr   = 1'b0;
    if (state_q != IDLE && cnt_q < nbytes_q) begin
      mem_a = base_q + {29'd0, cnt_q};
    end
    if (state_q == STORE) begin
      mem_dout = wr_byte;
      mem_wr   = rdy_in;
    end
  end

  assign if_ready  = if_ready_q;
  assign lsb_ready = lsb_ready_q;
  assign if_data   = if_data_q;
  assign lsb_rdata = lsb_rdata_q;
  assign mem_busy  = (state_q != IDLE) || if_ready_q || lsb_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests for mem_arbiter against a byte RAM model
// with one cycle of read latency.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_data;
  logic        lsb_req;
  logic        lsb_wr;
  logic [1:0]  lsb_len;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic        lsb_ready;
  logic [31:0] lsb_rdata;
  logic        clear;
  logic        mem_busy;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_data   (if_data),
    .lsb_req   (lsb_req),
    .lsb_wr    (lsb_wr),
    .lsb_len   (lsb_len),
    .lsb_addr  (lsb_addr),
    .lsb_wdata (lsb_wdata),
    .lsb_ready (lsb_ready),
    .lsb_rdata (lsb_rdata),
    .clear     (clear),
    .mem_busy  (mem_busy),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .mem_a     (mem_a),
    .mem_wr    (mem_wr)
  );

  always #5 clk_in = ~clk_in;

  // RAM model, indexed by the low 14 address bits; backdoor port for preload.
  logic [7:0]  ram [0:16383];
  logic        bd_we = 1'b0;
  logic [13:0] bd_addr = 14'h0;
  logic [7:0]  bd_data = 8'h0;
  always @(posedge clk_in) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_wr) ram[mem_a[13:0]] <= mem_dout;
    mem_din <= ram[mem_a[13:0]];
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a[13:0]; bd_data = d;
    step();
    bd_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    step(); step();
    n_checks++;
    if ({if_ready, lsb_ready, mem_busy, mem_wr} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {if_ready, lsb_ready, mem_busy, mem_wr});
    end
    n_checks++;
    if (mem_a !== 32'h0 || mem_dout !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_ram_bus: mem_a=%h mem_dout=%h expected 0", mem_a, mem_dout);
    end
    n_checks++;
    if (if_data !== 32'h0 || lsb_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: if_data=%h lsb_rdata=%h expected 0", if_data, lsb_rdata);
    end
    rst_in = 1'b0;
    $display("reset: outputs checked idle");
  endtask

  task automatic test_fetch();
    logic [31:0] exp_a;
    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h10); poke(32'h103, 8'h00);
    if_req = 1'b1; if_addr = 32'h100;
    step();
    if_addr = 32'hDEAD_0000;   // ignored after grant
    for (int c = 0; c <= 5; c++) begin
      exp_a = (c < 4) ? 32'h100 + 32'(c) : 32'h0;
      n_checks++;
      if (mem_a !== exp_a || mem_wr !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch_addr c%0d: mem_a=%h wr=%b expected %h wr=0", c, mem_a, mem_wr, exp_a);
      end
      n_checks++;
      if (if_ready !== (c == 5) || mem_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL fetch_ready c%0d: if_ready=%b busy=%b expected %b busy=1", c, if_ready, mem_busy, c == 5);
      end
      if (c < 5) step();
    end
    n_checks++;
    if (if_data !== 32'h0010_0513) begin
      n_fail++;
      $display("FAIL fetch_data: if_data=%h expected 00100513", if_data);
    end
    if_req = 1'b0;
    step();
    n_checks++;
    if (mem_busy !== 1'b0 || if_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_idle: busy=%b if_ready=%b expected 0 0", mem_busy, if_ready);
    end
    $display("fetch: addr=00000100 data=%h", if_data);
  endtask

  task automatic test_store();
    logic [31:0] exp_a;
    logic [7:0]  exp_d;
    poke(32'h2002, 8'h77);
    lsb_wr = 1'b1; lsb_len = 2'd1; lsb_addr = 32'h2000; lsb_wdata = 32'hDEAD_BEEF; lsb_req = 1'b1;
    step();
    lsb_wdata = 32'h0BAD_F00D; lsb_addr = 32'h3000;   // ignored after grant
    for (int c = 0; c <= 2; c++) begin
      exp_a = (c < 2) ? 32'h2000 + 32'(c) : 32'h0;
      exp_d = (c == 0) ? 8'hEF : (c == 1) ? 8'hBE : 8'h00;
      n_checks++;
      if (mem_a !== exp_a || mem_dout !== exp_d || mem_wr !== (c < 2)) begin
        n_fail++;
        $display("FAIL store_bus c%0d: a=%h d=%h wr=%b expected a=%h d=%h wr=%b",
                 c, mem_a, mem_dout, mem_wr, exp_a, exp_d, c < 2);
      end
      n_checks++;
      if (lsb_ready !== (c == 2)) begin
        n_fail++;
        $display("FAIL store_ready c%0d: lsb_ready=%b expected %b", c, lsb_ready, c == 2);
      end
      if (c < 2) step();
    end
    lsb_req = 1'b0; lsb_wr = 1'b0;
    step();
    n_checks++;
    if ({ram[14'h2002], ram[14'h2001], ram[14'h2000]} !== 24'h77BEEF) begin
      n_fail++;
      $display("FAIL store_ram: ram[2002..2000]=%h expected 77beef",
               {ram[14'h2002], ram[14'h2001], ram[14'h2000]});
    end
    $display("store: addr=00002000 len=2 wdata=deadbeef");
  endtask

  task automatic test_conflict();
    logic [31:0] exp_a;
    logic        exp_load_first;
    logic        done_l, done_f, load_first;
    rst_in = 1'b1; step(); rst_in = 1'b0;
    poke(32'h30, 8'h9C); poke(32'h31, 8'h4E);
    lsb_wr = 1'b0; lsb_len = 2'd0; lsb_addr = 32'h30; lsb_req = 1'b1;
    if_addr = 32'h100; if_req = 1'b1;
    step();
    n_checks++;
    if (mem_a !== 32'h30) begin
      n_fail++;
      $display("FAIL conflict_first_grant: mem_a=%h expected 00000030", mem_a);
    end
    step(); step();
    n_checks++;
    if (lsb_ready !== 1'b1 || lsb_rdata !== 32'h0000_009C || if_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL conflict_load: ready=%b rdata=%h if_ready=%b expected 1 0000009c 0",
               lsb_ready, lsb_rdata, if_ready);
    end
    $display("conflict: load addr=00000030 data=%h", lsb_rdata);
    lsb_addr = 32'h31;   // LSB keeps requesting: a second tie
    step();
`ifdef MEM_ARB_RR_EN
    exp_a = 32'h100;
    exp_load_first = 1'b0;
`else
    exp_a = 32'h31;
    exp_load_first = 1'b1;
`endif
    n_checks++;
    if (mem_a !== exp_a) begin
      n_fail++;
      $display("FAIL conflict_second_grant: mem_a=%h expected %h", mem_a, exp_a);
    end
    done_l = 1'b0; done_f = 1'b0; load_first = 1'b0;
    for (int c = 0; c < 30 && !(done_l && done_f); c++) begin
      if (lsb_ready) begin
        n_checks++;
        if (lsb_rdata !== 32'h0000_004E) begin
          n_fail++;
          $display("FAIL conflict_load2: rdata=%h expected 0000004e", lsb_rdata);
        end
        if (!done_f) load_first = 1'b1;
        done_l = 1'b1; lsb_req = 1'b0;
        $display("conflict: load addr=00000031 data=%h", lsb_rdata);
      end
      if (if_ready) begin
        n_checks++;
        if (if_data !== 32'h0010_0513) begin
          n_fail++;
          $display("FAIL conflict_fetch: if_data=%h expected 00100513", if_data);
        end
        done_f = 1'b1; if_req = 1'b0;
        $display("conflict: fetch addr=00000100 data=%h", if_data);
      end
      step();
    end
    n_checks++;
    if (!(done_l && done_f)) begin
      n_fail++;
      $display("FAIL conflict_timeout: load_done=%b fetch_done=%b expected 1 1", done_l, done_f);
      lsb_req = 1'b0; if_req = 1'b0;
    end
    n_checks++;
    if (load_first !== exp_load_first) begin
      n_fail++;
      $display("FAIL conflict_order: load_first=%b expected %b", load_first, exp_load_first);
    end
  endtask

  task automatic test_flush_fetch();
    int seen;
    if_req = 1'b1; if_addr = 32'h100;
    step(); step(); step();   // cycle 2
    n_checks++;
    if (mem_busy !== 1'b1 || mem_a !== 32'h102) begin
      n_fail++;
      $display("FAIL flush_fetch_pre: busy=%b mem_a=%h expected 1 00000102", mem_busy, mem_a);
    end
    clear = 1'b1; if_req = 1'b0;
    step();
    clear = 1'b0;
    n_checks++;
    if (mem_busy !== 1'b0 || if_ready !== 1'b0 || mem_a !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_fetch_abort: busy=%b if_ready=%b mem_a=%h expected 0 0 0", mem_busy, if_ready, mem_a);
    end
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (if_ready) seen++;
      step();
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL flush_fetch_noready: pulses=%0d expected 0", seen);
    end
    $display("flush: fetch aborted in cycle 2");
  endtask

  task automatic test_flush_store();
    poke(32'h2100, 8'h00); poke(32'h2101, 8'h00); poke(32'h2102, 8'h00); poke(32'h2103, 8'h00);
    lsb_wr = 1'b1; lsb_len = 2'd2; lsb_addr = 32'h2100; lsb_wdata = 32'h1122_3344; lsb_req = 1'b1;
    step(); step();   // cycle 1
    clear = 1'b1;
    step();           // cycle 2
    clear = 1'b0;
    n_checks++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h2102 || mem_dout !== 8'h22) begin
      n_fail++;
      $display("FAIL flush_store_c2: wr=%b a=%h d=%h expected 1 00002102 22", mem_wr, mem_a, mem_dout);
    end
    step();           // cycle 3
    n_checks++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h2103 || lsb_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_store_c3: wr=%b a=%h ready=%b expected 1 00002103 0", mem_wr, mem_a, lsb_ready);
    end
    step();           // cycle 4
    n_checks++;
    if (lsb_ready !== 1'b1 || mem_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_store_ready: ready=%b wr=%b expected 1 0", lsb_ready, mem_wr);
    end
    lsb_req = 1'b0; lsb_wr = 1'b0;
    step();
    n_checks++;
    if ({ram[14'h2103], ram[14'h2102], ram[14'h2101], ram[14'h2100]} !== 32'h1122_3344) begin
      n_fail++;
      $display("FAIL flush_store_ram: ram=%h expected 11223344",
               {ram[14'h2103], ram[14'h2102], ram[14'h2101], ram[14'h2100]});
    end
    $display("flush: store addr=00002100 completed despite clear");
  endtask

  task automatic test_pause_wrap();
    logic [31:0] exp_a;
    poke(32'hFFFF_FFFE, 8'hA1); poke(32'hFFFF_FFFF, 8'hB2); poke(32'h0, 8'hC3); poke(32'h1, 8'hD4);
    lsb_wr = 1'b0; lsb_len = 2'd2; lsb_addr = 32'hFFFF_FFFE; lsb_req = 1'b1;
    step();
    for (int c = 0; c <= 8; c++) begin
      if (c == 1) rdy_in = 1'b0;
      if (c == 4) rdy_in = 1'b1;
      case (c)
        0:       exp_a = 32'hFFFF_FFFE;
        1, 2, 3, 4: exp_a = 32'hFFFF_FFFF;
        5:       exp_a = 32'h0;
        6:       exp_a = 32'h1;
        default: exp_a = 32'h0;
      endcase
      n_checks++;
      if (mem_a !== exp_a || lsb_ready !== (c == 8)) begin
        n_fail++;
        $display("FAIL pause_wrap c%0d: mem_a=%h ready=%b expected %h %b", c, mem_a, lsb_ready, exp_a, c == 8);
      end
      if (c < 8) step();
    end
    n_checks++;
    if (lsb_rdata !== 32'hD4C3_B2A1) begin
      n_fail++;
      $display("FAIL pause_wrap_data: rdata=%h expected d4c3b2a1", lsb_rdata);
    end
    lsb_req = 1'b0;
    step();
    $display("pause: load addr=fffffffe len=4 data=%h", lsb_rdata);
  endtask

  task automatic test_pause_store_reset();
    poke(32'h2201, 8'h00); poke(32'h2202, 8'h55);
    lsb_wr = 1'b1; lsb_len = 2'd2; lsb_addr = 32'h2200; lsb_wdata = 32'hCAFE_F00D; lsb_req = 1'b1;
    step();           // cycle 0
    n_checks++;
    if (mem_wr !== 1'b1 || mem_dout !== 8'h0D) begin
      n_fail++;
      $display("FAIL rst_store_c0: wr=%b d=%h expected 1 0d", mem_wr, mem_dout);
    end
    step();           // cycle 1, paused
    rdy_in = 1'b0;
    #1;
    n_checks++;
    if (mem_wr !== 1'b0 || mem_a !== 32'h2201) begin
      n_fail++;
      $display("FAIL pause_store_wr: wr=%b a=%h expected 0 00002201", mem_wr, mem_a);
    end
    step();           // cycle 2
    rdy_in = 1'b1;
    #1;
    n_checks++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h2201 || mem_dout !== 8'hF0) begin
      n_fail++;
      $display("FAIL pause_store_resume: wr=%b a=%h d=%h expected 1 00002201 f0", mem_wr, mem_a, mem_dout);
    end
    rst_in = 1'b1; lsb_req = 1'b0; lsb_wr = 1'b0;
    step();
    n_checks++;
    if ({if_ready, lsb_ready, mem_busy, mem_wr} !== 4'b0 || mem_a !== 32'h0 || mem_dout !== 8'h0 ||
        if_data !== 32'h0 || lsb_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_store: flags=%b a=%h d=%h if_data=%h rdata=%h expected all 0",
               {if_ready, lsb_ready, mem_busy, mem_wr}, mem_a, mem_dout, if_data, lsb_rdata);
    end
    rst_in = 1'b0;
    step();
    n_checks++;
    if (ram[14'h2202] !== 8'h55) begin
      n_fail++;
      $display("FAIL rst_store_ram: ram[2202]=%h expected 55", ram[14'h2202]);
    end
    $display("reset: store addr=00002200 abandoned");
  endtask

  task automatic test_clear_idle();
    logic done;
    if_req = 1'b1; if_addr = 32'h100; clear = 1'b1;
    step();
    n_checks++;
    if (mem_busy !== 1'b0 || mem_a !== 32'h0) begin
      n_fail++;
      $display("FAIL clear_idle_nogrant: busy=%b a=%h expected 0 0", mem_busy, mem_a);
    end
    clear = 1'b0;
    step();
    n_checks++;
    if (mem_busy !== 1'b1 || mem_a !== 32'h100) begin
      n_fail++;
      $display("FAIL clear_idle_grant: busy=%b a=%h expected 1 00000100", mem_busy, mem_a);
    end
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      step();
      if (if_ready) begin
        done = 1'b1; if_req = 1'b0;
      end
    end
    n_checks++;
    if (!done || if_data !== 32'h0010_0513) begin
      n_fail++;
      $display("FAIL clear_idle_fetch: done=%b data=%h expected 1 00100513", done, if_data);
    end
    if_req = 1'b0;
    step();
    $display("clear: idle grant suppressed, fetch data=%h", if_data);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    lsb_req = 1'b0; lsb_wr = 1'b0; lsb_len = 2'd0; lsb_addr = 32'h0; lsb_wdata = 32'h0;
    test_reset();
    test_fetch();
    test_store();
    test_conflict();
    test_flush_fetch();
    test_flush_store();
    test_pause_wrap();
    test_pause_store_reset();
    test_clear_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
